// File: rtl/mem_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_stage -- RV32I memory pipeline stage (EX/MEM -> MEM/WB)
//
// Non-memory instructions pass straight to the MEM/WB outputs with one cycle
// of latency. Loads and stores are captured in IDLE, then issued from ACCESS
// until dmem_ack. The upstream stages are stalled while the access is
// outstanding.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   When defined, a misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0)
//   is not issued. Instead, trap pulses for one cycle.
//   When undefined, the trap port does not exist. Misaligned accesses then use
//   the aligned word, and bytes beyond bit 31 are dropped.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   i_valid             : EX/MEM holds a live instruction
//   rs_2, rd_num        : store data, destination register
//   alu_out             : effective address or ALU result
//   opcode, func_3      : RV32I opcode and access width/sign
//   op_type             : instruction writes rd
//   dmem_req/we/addr/wdata/be : registered data-memory request
//   dmem_ack, dmem_rdata      : memory completion and read word
//   stall               : hold upstream stages
//   wb_valid/rd_num/data/we   : registered MEM/WB outputs
//   trap                : misaligned-access pulse (MISALIGN_TRAP_EN only)
// -----------------------------------------------------------------------------
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] rs_2,
    input  logic [4:0]  rd_num,
    input  logic [31:0] alu_out,
    input  logic [6:0]  opcode,
    input  logic [2:0]  func_3,
    input  logic        op_type,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_rd_num,
    output logic [31:0] wb_data,
    output logic        wb_we
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        trap
`endif
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic {ST_IDLE = 1'b0, ST_ACCESS = 1'b1} state_t;

    state_t      r_state;
    logic [4:0]  r_rd;
    logic [2:0]  r_f3;
    logic [1:0]  r_lane;
    logic        r_store;

    logic        w_is_load;
    logic        w_is_store;
    logic        w_is_mem;
    logic        w_trap;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_is_load  = (opcode == OP_LOAD);
    assign w_is_store = (opcode == OP_STORE);
    assign w_is_mem   = w_is_load | w_is_store;

`ifdef MISALIGN_TRAP_EN
    // A half access is misaligned on an odd address. A word access is
    // misaligned on any non-zero offset.
    assign w_trap = w_is_mem &&
                    ((((func_3 == 3'b001) || (func_3 == 3'b101)) && alu_out[0]) ||
                     ((func_3 == 3'b010) && (alu_out[1:0] != 2'b00)));
`else
    assign w_trap = 1'b0;
`endif

    // Byte enables and lane-replicated write data for the access being accepted.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = rs_2;
        if (w_is_store) begin
            case (func_3)
                3'b000: begin
                    w_be    = 4'b0001 << alu_out[1:0];
                    w_wdata = {4{rs_2[7:0]}};
                end
                3'b001: begin
                    // Shifting into a 4-bit result drops the lane beyond bit 31.
                    w_be    = 4'b0011 << alu_out[1:0];
                    w_wdata = {2{rs_2[15:0]}};
                end
                3'b010: begin
                    w_be    = 4'b1111;
                    w_wdata = rs_2;
                end
                default: begin
                    w_be    = 4'b0000;
                    w_wdata = rs_2;
                end
            endcase
        end else begin
            w_be    = 4'b1111;
            w_wdata = rs_2;
        end
    end

    // Lane extraction from the read word. A half at lane 3 has no upper byte.
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = dmem_rdata[7:0];
            2'd1:    w_byte = dmem_rdata[15:8];
            2'd2:    w_byte = dmem_rdata[23:16];
            2'd3:    w_byte = dmem_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        case (r_lane)
            2'd0:    w_half = dmem_rdata[15:0];
            2'd1:    w_half = dmem_rdata[23:8];
            2'd2:    w_half = dmem_rdata[31:16];
            2'd3:    w_half = {8'h00, dmem_rdata[31:24]};
            default: w_half = 16'h0000;
        endcase
    end

    // Sign/zero extension of the selected lane. Reserved widths return zero.
    always_comb begin
        case (r_f3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = dmem_rdata;
            3'b100:  w_load_data = {24'h000000, w_byte};
            3'b101:  w_load_data = {16'h0000, w_half};
            default: w_load_data = 32'h00000000;
        endcase
    end

    // Stall covers the accept cycle of an issued access and every ACCESS cycle
    // up to, but not including, the ack cycle.
    assign stall = !rst &&
                   (((r_state == ST_IDLE) && i_valid && w_is_mem && !w_trap) ||
                    ((r_state == ST_ACCESS) && !dmem_ack));

    // Stage FSM with registered memory-request and write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd       <= 5'd0;
            r_f3       <= 3'd0;
            r_lane     <= 2'd0;
            r_store    <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_be    <= 4'b0000;
            dmem_addr  <= 32'h00000000;
            dmem_wdata <= 32'h00000000;
            wb_valid   <= 1'b0;
            wb_we      <= 1'b0;
            wb_rd_num  <= 5'd0;
            wb_data    <= 32'h00000000;
`ifdef MISALIGN_TRAP_EN
            trap       <= 1'b0;
`endif
        end else begin
            wb_valid <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            trap     <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        if (!w_is_mem) begin
                            wb_valid  <= 1'b1;
                            wb_data   <= alu_out;
                            wb_rd_num <= rd_num;
                            wb_we     <= op_type && (rd_num != 5'd0);
                        end else if (w_trap) begin
`ifdef MISALIGN_TRAP_EN
                            trap <= 1'b1;
`endif
                        end else begin
                            r_rd       <= rd_num;
                            r_f3       <= func_3;
                            r_lane     <= alu_out[1:0];
                            r_store    <= w_is_store;
                            dmem_req   <= 1'b1;
                            dmem_we    <= w_is_store;
                            dmem_be    <= w_be;
                            dmem_addr  <= {alu_out[31:2], 2'b00};
                            dmem_wdata <= w_wdata;
                            r_state    <= ST_ACCESS;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ack) begin
                        dmem_req  <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_rd_num <= r_rd;
                        wb_we     <= !r_store && (r_rd != 5'd0);
                        wb_data   <= r_store ? 32'h00000000 : w_load_data;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_state <= ST_ACCESS;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] rs_2;
    logic [4:0]  rd_num;
    logic [31:0] alu_out;
    logic [6:0]  opcode;
    logic [2:0]  func_3;
    logic        op_type;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd_num;
    logic [31:0] wb_data;
    logic        wb_we;
`ifdef MISALIGN_TRAP_EN
    logic        trap;
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .rs_2(rs_2), .rd_num(rd_num),
        .alu_out(alu_out), .opcode(opcode), .func_3(func_3), .op_type(op_type),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .stall(stall), .wb_valid(wb_valid),
        .wb_rd_num(wb_rd_num), .wb_data(wb_data), .wb_we(wb_we)
`ifdef MISALIGN_TRAP_EN
        , .trap(trap)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference load result: pick bytes out of the word arithmetically.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int lane, input logic [31:0] w);
        int unsigned b[4];
        int unsigned lo, hi, h;
        for (int i = 0; i < 4; i++) b[i] = (w >> (8 * i)) & 32'd255;
        lo = b[lane];
        hi = (lane < 3) ? b[lane + 1] : 32'd0;
        h  = hi * 32'd256 + lo;
        case (f3)
            3'd0:    return (lo >= 32'd128) ? lo + 32'hFFFFFF00 : lo;
            3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF0000 : h;
            3'd2:    return w;
            3'd4:    return lo;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_be(input int kind, input logic [2:0] f3, input int lane);
        if (kind == 1) return 32'd15;
        case (f3)
            3'd0:    return 32'd1 << lane;
            3'd1:    return (32'd3 << lane) & 32'd15;
            3'd2:    return 32'd15;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'd0:    return (d & 32'hFF) * 32'h01010101;
            3'd1:    return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int off;
        off = a % 4;
        if (f3 == 3'd1 || f3 == 3'd5) return (off % 2) != 0;
        if (f3 == 3'd2) return off != 0;
        return 1'b0;
    endfunction

    // kind: 0 = ALU op, 1 = load, 2 = store. Called at posedge+1.
    task automatic run_instr(input int kind, input logic [31:0] addr, input logic [31:0] data,
                             input logic [4:0] rd, input logic [2:0] f3, input logic opt,
                             input int ack_delay, input logic [31:0] rdata);
        bit exp_trap;
        int lane;
        int stall_cnt;
        lane     = int'(addr % 4);
        exp_trap = TRAP_EN && (kind != 0) && ref_misaligned(f3, addr);
        opcode   = (kind == 0) ? 7'b0110011 : (kind == 1) ? 7'b0000011 : 7'b0100011;
        alu_out  = addr; rs_2 = data; rd_num = rd; func_3 = f3; op_type = opt;
        i_valid  = 1'b1;
        #1;
        check_val("accept_stall", 32'(stall), 32'((kind != 0) && !exp_trap));
        stall_cnt = stall ? 1 : 0;
        @(posedge clk); #1;
        i_valid = 1'b0; alu_out = $urandom; rs_2 = $urandom; rd_num = 5'($urandom);
        if (kind == 0) begin
            check_val("alu_wb_valid", 32'(wb_valid), 32'd1);
            check_val("alu_wb_rd", 32'(wb_rd_num), 32'(rd));
            check_val("alu_wb_data", wb_data, addr);
            check_val("alu_wb_we", 32'(wb_we), 32'(opt && rd != 5'd0));
            check_val("alu_no_req", 32'(dmem_req), 32'd0);
        end else if (exp_trap) begin
`ifdef MISALIGN_TRAP_EN
            check_val("trap_pulse", 32'(trap), 32'd1);
`endif
            check_val("trap_wb_valid", 32'(wb_valid), 32'd0);
            check_val("trap_no_req", 32'(dmem_req), 32'd0);
        end else begin
            check_val("mem_wb_idle", 32'(wb_valid), 32'd0);
            for (int c = 0; c <= ack_delay; c++) begin
                check_val("req", 32'(dmem_req), 32'd1);
                check_val("addr", dmem_addr, addr & 32'hFFFFFFFC);
                check_val("we", 32'(dmem_we), 32'(kind == 2));
                check_val("be", 32'(dmem_be), ref_be(kind, f3, lane));
                if (kind == 2) check_val("wdata", dmem_wdata, ref_wdata(f3, data));
                dmem_ack   = (c == ack_delay);
                dmem_rdata = (c == ack_delay) ? rdata : $urandom;
                #1;
                check_val("access_stall", 32'(stall), 32'(c != ack_delay));
                if (stall) stall_cnt++;
                @(posedge clk); #1;
                dmem_ack = 1'b0;
            end
            check_val("stall_cycles", 32'(stall_cnt), 32'(ack_delay + 1));
            check_val("mem_wb_valid", 32'(wb_valid), 32'd1);
            check_val("mem_wb_rd", 32'(wb_rd_num), 32'(rd));
            check_val("mem_wb_we", 32'(wb_we), 32'((kind == 1) && rd != 5'd0));
            check_val("mem_wb_data", wb_data, (kind == 1) ? ref_load(f3, lane, rdata) : 32'd0);
            check_val("req_drop", 32'(dmem_req), 32'd0);
        end
    endtask

    // One cycle with no live instruction; a stray ack must be ignored.
    task automatic idle_cycle(input logic ack);
        i_valid = 1'b0; dmem_ack = ack; dmem_rdata = $urandom;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check_val("idle_wb_valid", 32'(wb_valid), 32'd0);
        check_val("idle_no_req", 32'(dmem_req), 32'd0);
    endtask

    logic [2:0] load_f3 [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        rst = 1'b1; i_valid = 1'b0; rs_2 = 32'd0; rd_num = 5'd0; alu_out = 32'd0;
        opcode = 7'd0; func_3 = 3'd0; op_type = 1'b0; dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_stall", 32'(stall), 32'd0);
        check_val("rst_req", 32'(dmem_req), 32'd0);
        check_val("rst_we", 32'(dmem_we), 32'd0);
        check_val("rst_be", 32'(dmem_be), 32'd0);
        check_val("rst_addr", dmem_addr, 32'd0);
        check_val("rst_wdata", dmem_wdata, 32'd0);
        check_val("rst_wb", {wb_valid, wb_we, wb_rd_num, wb_data[24:0]}, 32'd0);
        check_val("rst_wb_data", wb_data, 32'd0);
`ifdef MISALIGN_TRAP_EN
        check_val("rst_trap", 32'(trap), 32'd0);
`endif
        rst = 1'b0;

        // Directed cases from the stage's worked examples.
        run_instr(0, 32'h10, 32'h0, 5'd5, 3'd0, 1'b1, 0, 32'h0);             // ADD x5
        idle_cycle(1'b1);
        run_instr(1, 32'h103, 32'h0, 5'd3, 3'd0, 1'b1, 3, 32'h80FFFFFF);     // LB
        run_instr(2, 32'h202, 32'h1234ABCD, 5'd0, 3'd1, 1'b0, 0, 32'h0);     // SH
        run_instr(1, 32'h0, 32'h0, 5'd0, 3'd5, 1'b1, 0, 32'h0000F00D);       // LHU x0
        run_instr(2, 32'h301, 32'hCAFEF00D, 5'd0, 3'd2, 1'b0, 1, 32'h0);     // SW misaligned
        idle_cycle(1'b0);

        // Reset in the middle of an access abandons it.
        opcode = 7'b0000011; func_3 = 3'd2; alu_out = 32'h400; rd_num = 5'd7; i_valid = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check_val("rst_mid_req1", 32'(dmem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_val("rst_mid_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("rst_mid_req0", 32'(dmem_req), 32'd0);
        check_val("rst_mid_wb0", 32'(wb_valid), 32'd0);
        dmem_ack = 1'b1; dmem_rdata = 32'h55AA55AA;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        check_val("late_ack_wb", 32'(wb_valid), 32'd0);
        check_val("late_ack_req", 32'(dmem_req), 32'd0);

        // Randomized mix of ALU ops, loads and stores.
        for (int n = 0; n < 300; n++) begin
            int kind;
            logic [2:0] f3;
            kind = $urandom_range(0, 2);
            f3   = (kind == 1) ? load_f3[$urandom_range(0, 7)] : 3'($urandom_range(0, 2));
            run_instr(kind, $urandom, $urandom, 5'($urandom), f3, 1'($urandom),
                      $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 i_valid  in  1  EX/MEM register holds a live instruction this cycle.
REQ-004 rs_2  in  32  store data.
REQ-005 rd_num  in  5  destination register number.
REQ-006 alu_out  in  32  effective address (load/store) or ALU result (other ops).
REQ-007 opcode  in  7  RV32I opcode; LOAD=0000011, STORE=0100011.
REQ-008 func_3  in  3  access width/sign.
REQ-009 op_type  in  1  1 = instruction writes rd.
REQ-010 dmem_req, dmem_we  out  1 each  memory request strobe and write enable.
REQ-011 dmem_addr  out  32  word-aligned address, low two bits zero.
REQ-012 dmem_wdata  out  32  lane-shifted store data; dmem_be  out  4  byte enables.
REQ-013 dmem_ack  in  1  request completed; dmem_rdata  in  32  read word, valid with ack.
REQ-014 stall  out  1  upstream stages hold; EX/MEM register does not advance.
REQ-015 wb_valid  out  1; wb_rd_num  out  5; wb_data  out  32; wb_we  out  1  MEM/WB outputs.
REQ-016 trap  out  1  misaligned access (present only with MISALIGN_TRAP_EN).

Function
REQ-017 States: IDLE, ACCESS; state register 1 bit.
REQ-018 IDLE, i_valid, opcode not LOAD/STORE: next cycle wb_valid=1, wb_data=alu_out, wb_rd_num=rd_num, wb_we=op_type&(rd_num!=0); stall=0; latency 1.
REQ-019 IDLE, i_valid, LOAD/STORE: capture address, data, rd_num, func_3, store flag; stall=1 combinationally this cycle; go to ACCESS.
REQ-020 ACCESS: dmem_req=1; dmem_addr, dmem_we, dmem_be, dmem_wdata stable until the ack cycle; stall=1.
REQ-021 ACCESS with dmem_ack=1: stall=0 that cycle; return to IDLE; next cycle wb_valid=1.
REQ-022 Ack in same cycle as request entry is impossible (req first asserted in ACCESS); ack sampled in IDLE ignored.
REQ-023 Store byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; wdata = byte/half replicated across all lanes.
REQ-024 Loads: dmem_be=1111, dmem_we=0; lane selected by addr[1:0].
REQ-025 LB/LH sign-extend; LBU/LHU zero-extend; LW unmodified; reserved func_3 (011,110,111) -> wb_data=0.
REQ-026 Load completion: wb_we=(rd_num!=0); store completion: wb_valid=1, wb_we=0, wb_data=0.
REQ-027 wb_* outputs registered; wb_valid is a single-cycle pulse per instruction; other wb_* hold last value.
REQ-028 i_valid=0 in IDLE: wb_valid=0 next cycle, no request.

Reset
REQ-029 rst on rising edge: state=IDLE, dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0, wb_valid=0, wb_we=0, wb_rd_num=0, wb_data=0, trap=0.
REQ-030 rst during ACCESS abandons the access; no wb_valid is produced for it; a later dmem_ack is ignored.
REQ-031 stall=0 while rst is high.

Configuration
REQ-032 Macro MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issues no request; next cycle trap=1 (one-cycle pulse), wb_valid=0, stall=0.
REQ-033 Macro absent: no trap port; misaligned accesses are issued using the aligned word and the REQ-023/025 lane rules; bytes beyond bit 31 are dropped.

Verification
REQ-034 ADD x5, alu_out=0x10: next cycle wb_valid=1, wb_rd_num=5, wb_data=0x10, wb_we=1, dmem_req never high.
REQ-035 LB x3 addr 0x103, ack after 3 ACCESS cycles, rdata=0x80FFFFFF: stall high 3 cycles (4 incl. accept cycle), dmem_addr=0x100, wb_data=0xFFFFFF80.
REQ-036 SH addr 0x202, rs_2=0x1234ABCD, ack 1st cycle: dmem_be=1100, dmem_we=1, dmem_wdata=0xABCDABCD, wb_we=0.
REQ-037 LHU x0 addr 0x0, rdata=0x0000F00D: wb_data=0x0000F00D, wb_we=0.
REQ-038 LW issued, rst asserted 2nd ACCESS cycle, ack next cycle: dmem_req=0 after reset edge, no wb_valid.
REQ-039 With MISALIGN_TRAP_EN, SW addr 0x301: trap=1 one cycle, dmem_req stays 0; without macro: dmem_addr=0x300, dmem_be=1111.
